// File: rtl/song_sequencer_pkg.sv
// Shared types and constants for the song sequencer and its step timer.
package song_sequencer_pkg;

  // Sequencer control states.
  typedef enum logic [2:0] {
    IDLE,
    FETCH0,
    FETCH1,
    PLAY,
    DONE
  } seq_state_t;

  // tempo_sel codes.
  localparam logic [1:0] TEMPO_NORM    = 2'b00;
  localparam logic [1:0] TEMPO_FAST    = 2'b01;
  localparam logic [1:0] TEMPO_SLOW    = 2'b10;
  localparam logic [1:0] TEMPO_FASTEST = 2'b11;

  // Note code that silences the tone generator.
  localparam logic [7:0] NOTE_REST = 8'd0;

  // Number of PLAY cycles in one step for a given tempo code.
  function automatic int unsigned step_len(input logic [1:0] sel, input int unsigned base);
    case (sel)
      TEMPO_FAST:    return base / 2;
      TEMPO_SLOW:    return base * 2;
      TEMPO_FASTEST: return base / 4;
      default:       return base;
    endcase
  endfunction

endpackage

// File: rtl/song_sequencer_step_timer.sv
// Step timer: loadable step down-counter with enable and zero flag, plus a
// saturating re-attack gap counter that runs on the same enable.
module step_timer import song_sequencer_pkg::*; #(
  parameter int          CNT_W      = 25,
  parameter int          GAP_W      = 21,
  parameter int unsigned GAP_CYCLES = 1048576
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_cnt,
  input  logic             i_load_gap,
  input  logic             i_en,
  output logic             o_zero,
  output logic             o_gap_active
);

  logic [CNT_W-1:0] r_step_cnt;
  logic [GAP_W-1:0] r_gap_cnt;

  // Load both counters at the start of a step, otherwise count down while enabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_step_cnt <= '0;
      r_gap_cnt  <= '0;
    end else if (i_load) begin
      r_step_cnt <= i_load_cnt;
      r_gap_cnt  <= i_load_gap ? GAP_W'(GAP_CYCLES) : '0;
    end else if (i_en) begin
      if (r_step_cnt != '0) r_step_cnt <= r_step_cnt - CNT_W'(1);
      if (r_gap_cnt != '0)  r_gap_cnt  <= r_gap_cnt - GAP_W'(1);
    end
  end

  assign o_zero       = (r_step_cnt == '0);
  assign o_gap_active = (r_gap_cnt != '0);

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks a synchronous song ROM at a selectable tempo and
// presents one note code per step, with pause, restart, loop and re-attack gap.
module song_sequencer import song_sequencer_pkg::*; #(
  parameter int unsigned STEP_CYCLES = 16777216,
  parameter int unsigned GAP_CYCLES  = 1048576,
  parameter int          ADDR_W      = 8
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              play,
  input  logic              restart,
  input  logic              loop,
  input  logic [1:0]        tempo_sel,
  input  logic [ADDR_W-1:0] song_last,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_note,
  output logic [7:0]        note_out,
  output logic              step_strobe,
  output logic              done
);

  // Wide enough for the slowest tempo (2*STEP_CYCLES - 1).
  localparam int CNT_W = $clog2(2 * STEP_CYCLES);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [7:0]        r_cur_note;
  logic [7:0]        r_prev_note;
  logic [7:0]        r_note_out;
  logic              w_zero;
  logic              w_gap_active;
  logic              w_load;
  logic              w_load_gap;
  logic              w_step_end;
  logic              w_at_last;
  logic [CNT_W-1:0]  w_load_cnt;

  assign w_load     = (r_state == FETCH1) && !restart;
  assign w_load_gap = (rom_note == r_prev_note) && (rom_note != NOTE_REST);
  assign w_load_cnt = CNT_W'(step_len(tempo_sel, STEP_CYCLES) - 1);
  assign w_step_end = (r_state == PLAY) && play && w_zero;
  assign w_at_last  = (r_rom_addr == song_last);

  step_timer #(
    .CNT_W      (CNT_W),
    .GAP_W      (GAP_W),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_step_timer (
    .i_clk        (CLK100MHZ),
    .i_rst_n      (CPU_RESETN),
    .i_load       (w_load),
    .i_load_cnt   (w_load_cnt),
    .i_load_gap   (w_load_gap),
    .i_en         ((r_state == PLAY) && play),
    .o_zero       (w_zero),
    .o_gap_active (w_gap_active)
  );

  // State register.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) r_state <= IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next-state logic; restart overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (play) w_state_nxt = FETCH0;
      FETCH0:  w_state_nxt = FETCH1;
      FETCH1:  w_state_nxt = PLAY;
      PLAY: begin
        if (w_step_end) begin
          if (!w_at_last || loop) w_state_nxt = FETCH0;
          else                    w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
    if (restart) w_state_nxt = play ? FETCH0 : IDLE;
  end

  // ROM address: advance or wrap at the end of each step, zero on restart.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_rom_addr <= '0;
    end else if (restart) begin
      r_rom_addr <= '0;
    end else if (w_step_end) begin
      if (!w_at_last) r_rom_addr <= r_rom_addr + ADDR_W'(1);
      else if (loop)  r_rom_addr <= '0;
    end
  end

  // Note capture; prev_note survives a loop wrap so repeats across it still gap.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_cur_note  <= NOTE_REST;
      r_prev_note <= NOTE_REST;
    end else if (restart) begin
      r_prev_note <= NOTE_REST;
    end else if (r_state == FETCH1) begin
      r_cur_note  <= rom_note;
      r_prev_note <= rom_note;
    end
  end

  // Registered note output: sounds only in PLAY, unpaused and past the gap.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)                                       r_note_out <= NOTE_REST;
    else if (restart)                                      r_note_out <= NOTE_REST;
    else if ((r_state == PLAY) && play && !w_gap_active)   r_note_out <= r_cur_note;
    else                                                   r_note_out <= NOTE_REST;
  end

  assign rom_addr    = r_rom_addr;
  assign note_out    = r_note_out;
  assign step_strobe = w_step_end && !restart;
  assign done        = (r_state == DONE);

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer with a step-level behavioural model.
module tb_song_sequencer;

  localparam int STEP = 8;
  localparam int GAP  = 2;
  localparam int AW   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          play = 1'b0;
  logic          restart = 1'b0;
  logic          loop = 1'b0;
  logic [1:0]    tempo_sel = 2'b00;
  logic [AW-1:0] song_last = 8'd3;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_note;
  logic [7:0]    note_out;
  logic          step_strobe;
  logic          done;

  logic [7:0] rom [256];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int n25 = 0;
  int n27 = 0;

  song_sequencer #(
    .STEP_CYCLES (STEP),
    .GAP_CYCLES  (GAP),
    .ADDR_W      (AW)
  ) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .play        (play),
    .restart     (restart),
    .loop        (loop),
    .tempo_sel   (tempo_sel),
    .song_last   (song_last),
    .rom_addr    (rom_addr),
    .rom_note    (rom_note),
    .note_out    (note_out),
    .step_strobe (step_strobe),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous song ROM: data one cycle after the address.
  always @(posedge clk) rom_note <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A song is a sequence of steps; each step spends two cycles fetching and then
  // needs len unpaused play cycles. m_pos counts cycles into the step (0,1 fetch,
  // then 2 + number of unpaused play cycles already spent).
  logic       m_active = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] m_addr = 8'd0;
  logic [7:0] m_cur = 8'd0;
  logic [7:0] m_prev = 8'd0;
  logic [7:0] m_note = 8'd0;
  int         m_pos = 0;
  int         m_len = STEP;
  int         m_gap = 0;
  logic       exp_strobe;

  function automatic int tempo_len(input logic [1:0] t);
    case (t)
      2'b01:   return STEP / 2;
      2'b10:   return STEP * 2;
      2'b11:   return STEP / 4;
      default: return STEP;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_done = 1'b0; m_addr = 8'd0; m_prev = 8'd0; m_note = 8'd0; m_pos = 0;
    end else begin
      // Note heard next cycle: current step's note once past the gap, unpaused.
      if (!restart && m_active && m_pos >= 2 && play && (m_pos - 2) >= m_gap) m_note = m_cur;
      else m_note = 8'd0;
      if (restart) begin
        m_addr = 8'd0; m_prev = 8'd0; m_done = 1'b0; m_active = play; m_pos = 0;
      end else if (m_done) begin
        m_done = 1'b1;
      end else if (!m_active) begin
        if (play) begin m_active = 1'b1; m_pos = 0; end
      end else if (m_pos == 0) begin
        m_pos = 1;
      end else if (m_pos == 1) begin
        m_cur  = rom[m_addr];
        m_gap  = (m_cur == m_prev && m_cur != 8'd0) ? GAP : 0;
        m_prev = m_cur;
        m_len  = tempo_len(tempo_sel);
        m_pos  = 2;
      end else if (play) begin
        if (m_pos - 2 == m_len - 1) begin
          if (m_addr != song_last)  begin m_addr = m_addr + 8'd1; m_pos = 0; end
          else if (loop)            begin m_addr = 8'd0; m_pos = 0; end
          else                      begin m_active = 1'b0; m_done = 1'b1; end
        end else begin
          m_pos = m_pos + 1;
        end
      end
    end
  end

  // Compare process: every cycle out of reset, mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_strobe = m_active && (m_pos >= 2) && play && (m_pos - 2 == m_len - 1) && !restart;
      check("rom_addr", 32'(rom_addr), 32'(m_addr));
      check("note_out", 32'(note_out), 32'(m_note));
      check("done", 32'(done), 32'(m_done));
      check("step_strobe", 32'(step_strobe), 32'(exp_strobe));
      if (note_out == 8'd25) n25++;
      if (note_out == 8'd27) n27++;
    end
  end

  // Wait (bounded) for the next strobe cycle; returns its cycle number.
  task automatic wait_strobe(input int budget, output int at);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (step_strobe !== 1'b1 && k < budget);
    check("strobe_within_budget", 32'(step_strobe), 32'd1);
    at = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3, t4, k;
    for (int a = 0; a < 256; a++) rom[a] = 8'd0;
    rom[0] = 8'd25; rom[1] = 8'd27; rom[2] = 8'd27; rom[3] = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_addr", 32'(rom_addr), 32'd0);
    check("reset_note", 32'(note_out), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_strobe", 32'(step_strobe), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 play = 1'b1;

    // Full song, loop=0, tempo 00: 10-cycle steps then DONE
    wait_strobe(40, t0);
    wait_strobe(40, t1); check("step_period_1", 32'(t1 - t0), 32'd10);
    wait_strobe(40, t2); check("step_period_2", 32'(t2 - t1), 32'd10);
    wait_strobe(40, t3); check("step_period_3", 32'(t3 - t2), 32'd10);
    @(negedge clk); @(negedge clk);
    check("done_set", 32'(done), 32'd1);
    check("done_note", 32'(note_out), 32'd0);
    check("cycles_note25", 32'(n25), 32'd8);
    check("cycles_note27_with_gap", 32'(n27), 32'd14);

    // play ignored in DONE
    @(posedge clk); #1 play = 1'b0;
    repeat (3) @(posedge clk);
    #1 play = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("done_hold", 32'(done), 32'd1);
    check("done_addr_hold", 32'(rom_addr), 32'd3);

    // restart leaves DONE
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0; loop = 1'b1;
    @(negedge clk);
    check("restart_done", 32'(done), 32'd0);
    check("restart_addr", 32'(rom_addr), 32'd0);
    k = 0;
    while (note_out != 8'd25 && k < 20) begin @(negedge clk); k++; end
    check("restart_note25", 32'(note_out), 32'd25);

    // loop=1: wrap 3->0 without extra cycles
    wait_strobe(40, t0);
    for (int i = 1; i <= 5; i++) begin
      wait_strobe(40, t1);
      check("loop_period", 32'(t1 - t0), 32'd10);
      check("loop_addr", 32'(rom_addr), 32'(i % 4));
      check("loop_not_done", 32'(done), 32'd0);
      t0 = t1;
    end

    // Pause 20 cycles at step_cnt=4 inside the next step
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 play = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pause_silent", 32'(note_out), 32'd0);
    repeat (15) @(posedge clk);
    #1 play = 1'b1;
    wait_strobe(60, t1);
    check("pause_period", 32'(t1 - t0), 32'd30);

    // Tempo changes take effect at the next fetch
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 tempo_sel = 2'b01;
    wait_strobe(40, t2); check("tempo_mid_step", 32'(t2 - t1), 32'd10);
    wait_strobe(40, t3); check("tempo_fast", 32'(t3 - t2), 32'd6);
    @(posedge clk); #1 tempo_sel = 2'b10;
    wait_strobe(60, t4); check("tempo_slow", 32'(t4 - t3), 32'd18);
    @(posedge clk); #1 tempo_sel = 2'b11;
    wait_strobe(40, t0); check("tempo_fastest", 32'(t0 - t4), 32'd4);

    // restart on the end-of-step cycle goes to address 0
    @(posedge clk); #1 tempo_sel = 2'b00; song_last = 8'd200;
    repeat (9) @(posedge clk);
    #1 restart = 1'b1;
    @(negedge clk);
    check("restart_masks_strobe", 32'(step_strobe), 32'd0);
    @(posedge clk); #1 restart = 1'b0;
    @(negedge clk);
    check("restart_at_end_addr", 32'(rom_addr), 32'd0);

    // Async reset mid-PLAY
    wait_strobe(40, t1);
    repeat (6) @(negedge clk);
    check("pre_reset_addr", 32'(rom_addr), 32'd1);
    check("pre_reset_note", 32'(note_out), 32'd27);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_note", 32'(note_out), 32'd0);
    check("async_reset_addr", 32'(rom_addr), 32'd0);
    check("async_reset_done", 32'(done), 32'd0);
    check("async_reset_strobe", 32'(step_strobe), 32'd0);

    // Randomized runs against the model
    for (int it = 0; it < 4; it++) begin
      rst_n = 1'b0; play = 1'b0; restart = 1'b0; tempo_sel = 2'b00;
      for (int a = 0; a < 256; a++) begin
        int r;
        r = $urandom_range(0, 4);
        rom[a] = (r < 2) ? 8'd0 : (r < 4) ? 8'd40 : 8'd52;
      end
      song_last = (it == 0) ? 8'd0 : (it == 3) ? 8'd255 : 8'($urandom_range(1, 7));
      loop = (it != 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int n = 0; n < ((it == 3) ? 1200 : 1500); n++) begin
        if (it != 3) begin
          play    = ($urandom_range(0, 99) < 85);
          restart = ($urandom_range(0, 99) < 2);
          if ($urandom_range(0, 99) < 3) tempo_sel = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 99) < 1) loop = ~loop;
        end else begin
          play = 1'b1; tempo_sel = 2'b11;
        end
        @(posedge clk); #1;
      end
    end
    restart = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
